// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with architectural HI/LO and MTHI/MTLO writes.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mt_en,
  input  logic             mt_sel,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem, quo;

  // Operand magnitudes at launch; only MULT/DIV (op[0]=0) are signed.
  logic             sgn_in, a_neg, b_neg, last;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign sgn_in = ~op[0];
  assign a_neg  = sgn_in & src_a[WIDTH-1];
  assign b_neg  = sgn_in & src_b[WIDTH-1];
  assign a_abs  = a_neg ? -src_a : src_a;
  assign b_abs  = b_neg ? -src_b : src_b;
  assign last   = (cnt == CW'(WIDTH-1));
  assign busy   = (state != IDLE);

  // Multiply step: add multiplicand into upper half when LSB set, then shift right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_mag : '0)};

  // Divide step: the shifted partial remainder is WIDTH+1 bits so the
  // compare/subtract cannot overflow; after a restore it always fits WIDTH.
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nxt;
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, b_mag});
  assign rem_nxt = rem_ge ? WIDTH'(rem_sh - {1'b0, b_mag}) : rem_sh[WIDTH-1:0];

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = div_zero ? '1 : (neg_q ? -quo : quo);
  assign rem_fix  = neg_r ? -rem : rem;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (src_b == '0);
            a_mag    <= a_abs;
            b_mag    <= b_abs;
            cnt      <= '0;
            acc      <= {{WIDTH{1'b0}}, b_abs};
            rem      <= '0;
            quo      <= a_abs;
          end else if (mt_en) begin
            if (mt_sel) hi <= mt_data;
            else        lo <= mt_data;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            rem <= rem_nxt;
            quo <= {quo[WIDTH-2:0], rem_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: transaction-level reference model with per-cycle
// compare, directed corner cases with literal results, then random traffic.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst, start, mt_en, mt_sel;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, mt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .mt_en(mt_en), .mt_sel(mt_sel), .mt_data(mt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Architectural result of one operation as {hi, lo}.
  function automatic logic [63:0] ref_res(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Model: an operation occupies 33 edges, then HI/LO update and done pulses.
  logic [31:0] m_hi, m_lo;
  logic        m_done;
  int          m_rem;
  logic [63:0] m_res;

  always @(posedge clk) begin
    if (rst) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (start) begin
          m_rem <= 33;
          m_res <= ref_res(op, src_a, src_b);
        end else if (mt_en) begin
          if (mt_sel) m_hi <= mt_data;
          else        m_lo <= mt_data;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_rem != 0));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_hi",   64'(hi),   64'(m_hi));
      chk("cyc_lo",   64'(lo),   64'(m_lo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_chk(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    launch(o, a, b);
    wait_done(lat);
    chk({nm, "_lat"}, 64'(lat), 64'd33);
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
    tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, pulses;
    rst = 1'b1; start = 1'b0; mt_en = 1'b0; mt_sel = 1'b0;
    op = 2'd0; src_a = '0; src_b = '0; mt_data = '0;
    tick();
    chk_en = 1'b1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    rst = 1'b0;
    tick();

    run_chk("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_chk("mult_neg",  2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_chk("mult_min",  2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_chk("div_n7_2",  2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_chk("divu_7_2",  2'd3, 32'd7,         32'd2,         32'd1,         32'd3);
    run_chk("div_7_n2",  2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run_chk("div_zero",  2'd2, 32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF);
    run_chk("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);

    mt_en = 1'b1; mt_sel = 1'b1; mt_data = 32'hA5A5_A5A5;
    tick();
    mt_en = 1'b0;
    chk("mthi_hi",   64'(hi),   64'hA5A5_A5A5);
    chk("mthi_lo",   64'(lo),   64'h8000_0000);
    chk("mthi_done", 64'(done), 64'd0);

    launch(2'd1, 32'd3, 32'd4);
    repeat (4) tick();
    op = 2'd3; src_a = 32'd9; src_b = 32'd3; start = 1'b1;
    mt_en = 1'b1; mt_sel = 1'b0; mt_data = 32'h1111;
    tick();
    start = 1'b0; mt_en = 1'b0;
    wait_done(lat);
    chk("midrun_lat", 64'(lat + 5), 64'd33);
    chk("midrun_hi",  64'(hi), 64'd0);
    chk("midrun_lo",  64'(lo), 64'd12);
    tick();

    launch(2'd3, 32'd100, 32'd7);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi",   64'(hi),   64'd0);
    chk("abort_lo",   64'(lo),   64'd0);
    pulses = 0;
    repeat (40) begin
      tick();
      if (done) pulses++;
    end
    chk("abort_nodone", 64'(pulses), 64'd0);
    run_chk("multu_2_3", 2'd1, 32'd2, 32'd3, 32'd0, 32'd6);

    repeat (3000) begin
      rst     = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 3) == 0);
      op      = 2'($urandom_range(0, 3));
      src_a   = pick();
      src_b   = pick();
      mt_en   = ($urandom_range(0, 4) == 0);
      mt_sel  = 1'($urandom_range(0, 1));
      mt_data = $urandom;
      tick();
    end
    rst = 1'b0; start = 1'b0; mt_en = 1'b0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
